// File: rtl/cla_multiword_add_ctrl_pkg.sv
// Shared definitions for the sequencers built around the chunked carry-lookahead adder.
package cla_multiword_add_ctrl_pkg;

  // Sequencer state encoding, reused by sibling sequencer blocks
  localparam int unsigned SEQ_STATE_W = 2;

  typedef enum logic [SEQ_STATE_W-1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } seq_state_e;

  // Width of a counter that walks 0..n-1; never narrower than one bit
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/carry_lookahead_adder.sv
// BIT-wide adder with a parallel-prefix (Kogge-Stone) carry network.
module carry_lookahead_adder #(
  parameter int BIT = 32
) (
  input  logic [BIT-1:0] i_a,
  input  logic [BIT-1:0] i_b,
  input  logic           i_carry,
  output logic [BIT-1:0] o_sum,
  output logic           o_carry
);

  // Enough prefix levels that every bit's group spans down to bit 0
  localparam int LVL = (BIT > 1) ? $clog2(BIT) : 1;

  logic [LVL:0][BIT-1:0] g;
  logic [LVL:0][BIT-1:0] p;
  logic [BIT:0]          c;

  assign g[0] = i_a & i_b;
  assign p[0] = i_a ^ i_b;

  // Each level merges a group with the one 2^l bits below it
  for (genvar l = 0; l < LVL; l++) begin : g_lvl
    for (genvar i = 0; i < BIT; i++) begin : g_bit
      if (i >= (1 << l)) begin : g_merge
        assign g[l+1][i] = g[l][i] | (p[l][i] & g[l][i-(1<<l)]);
        assign p[l+1][i] = p[l][i] & p[l][i-(1<<l)];
      end else begin : g_pass
        assign g[l+1][i] = g[l][i];
        assign p[l+1][i] = p[l][i];
      end
    end
  end

  // After the last level g/p cover bits [i:0], so the carry-in folds in directly
  assign c[0] = i_carry;
  for (genvar i = 0; i < BIT; i++) begin : g_carry
    assign c[i+1] = g[LVL][i] | (p[LVL][i] & i_carry);
  end

  assign o_sum   = p[0] ^ c[BIT-1:0];
  assign o_carry = c[BIT];

endmodule

// File: rtl/cla_multiword_add_ctrl.sv
// Wide (WORDS*BIT) adder that reuses one BIT-wide carry-lookahead adder over WORDS
// cycles, chaining the carry between chunks, behind valid/ready on both sides.
module cla_multiword_add_ctrl
  import cla_multiword_add_ctrl_pkg::*;
#(
  parameter int BIT   = 32,
  parameter int WORDS = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rstn,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [BIT*WORDS-1:0] i_data_a,
  input  logic [BIT*WORDS-1:0] i_data_b,
  input  logic                 i_carry,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [BIT*WORDS-1:0] o_data_s,
  output logic                 o_carry,
  output logic                 o_busy
);

  localparam int unsigned CW = cnt_width(WORDS);
  localparam logic [CW-1:0] LAST = CW'(WORDS - 1);

  seq_state_e                  state_q, state_d;
  logic [CW-1:0]               cnt_q, cnt_d;
  logic [WORDS-1:0][BIT-1:0]   a_q, a_d;
  logic [WORDS-1:0][BIT-1:0]   b_q, b_d;
  logic [WORDS-1:0][BIT-1:0]   s_q, s_d;
  logic                        carry_q, carry_d;
  logic                        cout_q, cout_d;

  logic [BIT-1:0]              add_a, add_b, add_s;
  logic                        add_co;

  // Chunk mux: pick the operand slice addressed by the counter
  always_comb begin
    add_a = '0;
    add_b = '0;
    for (int k = 0; k < WORDS; k++) begin
      if (cnt_q == CW'(k)) begin
        add_a = a_q[k];
        add_b = b_q[k];
      end
    end
  end

  carry_lookahead_adder #(.BIT(BIT)) u_carry_lookahead_adder (
    .i_a     (add_a),
    .i_b     (add_b),
    .i_carry (carry_q),
    .o_sum   (add_s),
    .o_carry (add_co)
  );

  // Next-state and datapath update; registers hold unless the state says otherwise
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    case (state_q)
      ST_IDLE: begin
        if (i_valid) begin
          a_d     = i_data_a;
          b_d     = i_data_b;
          carry_d = i_carry;
          cnt_d   = '0;
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        for (int k = 0; k < WORDS; k++) begin
          if (cnt_q == CW'(k)) s_d[k] = add_s;
        end
        carry_d = add_co;
        if (cnt_q == LAST) begin
          cout_d  = add_co;
          cnt_d   = '0;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        if (i_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset discards any in-flight operation
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
    end
  end

  // Handshake outputs are pure state decodes, so i_ready never reaches o_ready combinationally
  assign o_ready  = (state_q == ST_IDLE);
  assign o_valid  = (state_q == ST_DONE);
  assign o_busy   = (state_q != ST_IDLE);
  assign o_data_s = s_q;
  assign o_carry  = cout_q;

endmodule

// File: tb/tb_cla_multiword_add_ctrl.sv
// Bench for the chunked wide adder: vector table, latency/backpressure/reset
// sequences, a WORDS=1 instance and a randomized scoreboard run.
module tb_cla_multiword_add_ctrl;

  localparam int BIT   = 32;
  localparam int WORDS = 4;
  localparam int W     = BIT * WORDS;

  logic         i_clk = 1'b0;
  logic         i_rstn;
  logic         i_valid, i_ready, i_carry;
  logic [W-1:0] i_data_a, i_data_b;
  logic         o_ready, o_valid, o_carry, o_busy;
  logic [W-1:0] o_data_s;

  logic        v1, r1, c1;
  logic [31:0] a1, b1, s1;
  logic        rdy1, vo1, co1, busy1;

  always #5 i_clk = ~i_clk;

  cla_multiword_add_ctrl #(.BIT(BIT), .WORDS(WORDS)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_valid(i_valid), .o_ready(o_ready),
    .i_data_a(i_data_a), .i_data_b(i_data_b), .i_carry(i_carry),
    .o_valid(o_valid), .i_ready(i_ready), .o_data_s(o_data_s),
    .o_carry(o_carry), .o_busy(o_busy)
  );

  cla_multiword_add_ctrl #(.BIT(32), .WORDS(1)) dut1 (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_valid(v1), .o_ready(rdy1),
    .i_data_a(a1), .i_data_b(b1), .i_carry(c1),
    .o_valid(vo1), .i_ready(r1), .o_data_s(s1),
    .o_carry(co1), .o_busy(busy1)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] s;
    logic         co;
  } vec_t;

  vec_t       tbl[8];
  logic [W:0] sbq[$];
  logic [W:0] cur_exp;
  int         checks = 0;
  int         failures = 0;
  int         n_acc = 0;
  int         n_res = 0;

  task automatic check(input string name, input logic [W:0] act, input logic [W:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: record handshakes that the coming edge will complete, then advance
  task automatic cyc();
    logic       acc;
    logic [W:0] e;
    acc = i_valid && o_ready;
    if (acc) sbq.push_back(cur_exp);
    if (o_valid && i_ready) begin
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_result: got %h with empty scoreboard", {o_carry, o_data_s});
      end else begin
        e = sbq.pop_front();
        check("result", {o_carry, o_data_s}, e);
        n_res++;
      end
    end
    @(posedge i_clk);
    @(negedge i_clk);
    if (acc) begin
      i_valid = 1'b0;
      n_acc++;
    end
  endtask

  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                       input logic [W:0] exp);
    i_data_a = a;
    i_data_b = b;
    i_carry  = cin;
    cur_exp  = exp;
    i_valid  = 1'b1;
  endtask

  task automatic drive_beh(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    logic [W:0] e;
    e = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    drive(a, b, cin, e);
  endtask

  task automatic wait_accept();
    int k = 0;
    while (i_valid && k < 50) begin
      cyc();
      k++;
    end
    if (i_valid) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: got no handshake in %0d cycles, required one", k);
      i_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int k = 0;
    while (sbq.size() > 0 && k < 100) begin
      cyc();
      k++;
    end
    if (sbq.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: got %0d results outstanding, required 0", sbq.size());
      sbq.delete();
    end
  endtask

  initial begin
    int         n;
    int         saw;
    int         sent;
    int         guard;
    int         a0;
    int         r0;
    logic [W:0] e1;
    logic [W-1:0] ra, rb;

    tbl[0] = '{a: '1, b: '0, cin: 1'b1, s: '0, co: 1'b1};
    tbl[1] = '{a: 128'h0000_0001_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, b: 128'h1, cin: 1'b0,
               s: 128'h0000_0002_0000_0000_0000_0000_0000_0000, co: 1'b0};
    tbl[2] = '{a: '0, b: '0, cin: 1'b0, s: '0, co: 1'b0};
    tbl[3] = '{a: '1, b: '1, cin: 1'b1, s: '1, co: 1'b1};
    tbl[4] = '{a: {32{4'h5}}, b: {32{4'hA}}, cin: 1'b0, s: '1, co: 1'b0};
    tbl[5] = '{a: {32{4'h5}}, b: {32{4'hA}}, cin: 1'b1, s: '0, co: 1'b1};
    tbl[6] = '{a: 128'h8000_0000_0000_0000_0000_0000_0000_0000,
               b: 128'h8000_0000_0000_0000_0000_0000_0000_0000, cin: 1'b0, s: '0, co: 1'b1};
    tbl[7] = '{a: 128'h0000_0000_FFFF_FFFF_0000_0000_FFFF_FFFF,
               b: 128'h0000_0000_0000_0001_0000_0000_0000_0001, cin: 1'b0,
               s: 128'h0000_0001_0000_0000_0000_0001_0000_0000, co: 1'b0};

    i_rstn = 1'b0; i_valid = 1'b0; i_ready = 1'b0; i_carry = 1'b0;
    i_data_a = '0; i_data_b = '0; cur_exp = '0;
    v1 = 1'b0; r1 = 1'b0; c1 = 1'b0; a1 = '0; b1 = '0;

    // Reset state
    @(negedge i_clk);
    check("rst_ready", {128'h0, o_ready}, 129'h1);
    check("rst_valid", {128'h0, o_valid}, 129'h0);
    check("rst_busy",  {128'h0, o_busy},  129'h0);
    check("rst_data",  {o_carry, o_data_s}, 129'h0);
    repeat (2) @(negedge i_clk);
    i_rstn = 1'b1;
    @(negedge i_clk);

    // Vector table, downstream always ready
    i_ready = 1'b1;
    for (int t = 0; t < 8; t++) begin
      drive(tbl[t].a, tbl[t].b, tbl[t].cin, {tbl[t].co, tbl[t].s});
      wait_accept();
      drain();
    end

    // Latency: accept edge through o_valid is WORDS+1 edges
    drive(tbl[0].a, tbl[0].b, tbl[0].cin, {tbl[0].co, tbl[0].s});
    cyc();
    n = 0;
    while (!o_valid && n < 20) begin
      cyc();
      n++;
    end
    check("latency_edges", 129'(n + 1), 129'(WORDS + 1));
    drain();

    // o_ready low for WORDS CALC cycles plus one DONE cycle
    drive(tbl[1].a, tbl[1].b, tbl[1].cin, {tbl[1].co, tbl[1].s});
    cyc();
    n = 0;
    while (!o_ready && n < 20) begin
      n++;
      cyc();
    end
    check("ready_low_cycles", 129'(n), 129'(WORDS + 1));
    drain();

    // Backpressure: hold DONE for 10 cycles with a second request pending
    i_ready = 1'b0;
    drive(tbl[7].a, tbl[7].b, tbl[7].cin, {tbl[7].co, tbl[7].s});
    cyc();
    n = 0;
    while (!o_valid && n < 20) begin
      cyc();
      n++;
    end
    e1 = {tbl[7].co, tbl[7].s};
    drive(tbl[3].a, tbl[3].b, tbl[3].cin, {tbl[3].co, tbl[3].s});
    for (int k = 0; k < 10; k++) begin
      check("bp_valid", {128'h0, o_valid}, 129'h1);
      check("bp_data",  {o_carry, o_data_s}, e1);
      check("bp_ready", {128'h0, o_ready}, 129'h0);
      cyc();
    end
    i_ready = 1'b1;
    cyc();
    check("bp_valid_drop", {128'h0, o_valid}, 129'h0);
    check("bp_ready_back", {128'h0, o_ready}, 129'h1);
    check("bp_not_yet_accepted", 129'(sbq.size()), 129'h0);
    cyc();
    check("bp_accepted_after", 129'(sbq.size()), 129'h1);
    drain();

    // Reset in the middle of CALC (counter at 2)
    drive(tbl[3].a, tbl[3].b, tbl[3].cin, {tbl[3].co, tbl[3].s});
    cyc();
    cyc();
    cyc();
    check("mid_busy", {128'h0, o_busy}, 129'h1);
    i_rstn = 1'b0;
    #1;
    check("mr_valid", {128'h0, o_valid}, 129'h0);
    check("mr_busy",  {128'h0, o_busy},  129'h0);
    check("mr_ready", {128'h0, o_ready}, 129'h1);
    check("mr_data",  {o_carry, o_data_s}, 129'h0);
    sbq.delete();
    saw = 0;
    repeat (3) begin
      if (o_valid) saw = 1;
      cyc();
    end
    i_rstn = 1'b1;
    repeat (6) begin
      if (o_valid) saw = 1;
      cyc();
    end
    check("mr_no_valid", 129'(saw), 129'h0);
    drive(tbl[6].a, tbl[6].b, tbl[6].cin, {tbl[6].co, tbl[6].s});
    wait_accept();
    drain();

    // WORDS=1 instance
    v1 = 1'b1; a1 = 32'hFFFF_FFFF; b1 = 32'h1; c1 = 1'b0; r1 = 1'b0;
    check("w1_ready", {128'h0, rdy1}, 129'h1);
    @(posedge i_clk);
    @(negedge i_clk);
    v1 = 1'b0;
    check("w1_edge1_valid", {128'h0, vo1}, 129'h0);
    check("w1_edge1_busy", {128'h0, busy1}, 129'h1);
    @(posedge i_clk);
    @(negedge i_clk);
    check("w1_edge2_valid", {128'h0, vo1}, 129'h1);
    check("w1_result", {96'h0, co1, s1}, 129'h1_0000_0000);
    r1 = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    r1 = 1'b0;
    check("w1_valid_drop", {128'h0, vo1}, 129'h0);

    // Randomized traffic with gaps and backpressure
    a0 = n_acc;
    r0 = n_res;
    sent = 0;
    guard = 0;
    while ((sent < 1000 || i_valid || sbq.size() > 0) && guard < 40000) begin
      if (!i_valid && sent < 1000 && $urandom_range(2) != 0) begin
        ra = {$urandom, $urandom, $urandom, $urandom};
        rb = {$urandom, $urandom, $urandom, $urandom};
        case ($urandom_range(3))
          0: ra = '1;
          1: rb = ~ra;
          default: ;
        endcase
        drive_beh(ra, rb, 1'($urandom_range(1)));
        sent++;
      end
      i_ready = ($urandom_range(3) != 0);
      cyc();
      guard++;
    end
    if (guard >= 40000) begin
      checks++;
      failures++;
      $display("FAIL random_timeout: got %0d sent, %0d pending", sent, sbq.size());
    end
    check("rand_accepted", 129'(n_acc - a0), 129'(1000));
    check("rand_results", 129'(n_res - r0), 129'(n_acc - a0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
